clk_gen: RTL and testbench

- Synthesizable programmable clock divider. Derives a slower clock, CLK, from the system clock.
- Clients such as the DISK memory model and DMA peripherals use CLK as their local timebase.
- Produces single-cycle edge strobes and a period counter for logic that stays in the system-clock domain.
- CLK is a registered output with no combinational path from any input.

---
 rtl/clk_gen_pkg.sv | 20 ++
 rtl/clk_gen_phase_ctr.sv | 43 ++++
 rtl/clk_gen.sv | 107 ++++++++++
 tb/tb_clk_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_gen_pkg.sv
// Shared definitions for the programmable clock divider: default widths,
// the minimum legal divide ratio and the ratio sanitiser.
package clk_gen_pkg;

   localparam int          DEF_CNT_W  = 16;
   localparam int          DEF_PCNT_W = 32;
   localparam int          DEF_DIV    = 2;
   localparam int unsigned MIN_DIV    = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } clk_state_t;

   // Ratios below MIN_DIV cannot form a high and a low phase, so they clamp up.
   function automatic int unsigned sanitize_div(input int unsigned n);
      return (n < MIN_DIV) ? MIN_DIV : n;
   endfunction

endpackage

// File: rtl/clk_gen_phase_ctr.sv
// Phase counter for one divided-clock period: counts 0..N-1 while advancing,
// and flags the last cycle plus the high/low shape of the next cycle.
module clk_gen_phase_ctr
   import clk_gen_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic             advance,
   input  logic [CNT_W-1:0] ratio,
   output logic             period_end,
   output logic             hi_next,
   output logic             fall_next
);

   localparam logic [CNT_W:0] ONE_X = {{CNT_W{1'b0}}, 1'b1};

   logic [CNT_W-1:0] phase;
   logic [CNT_W:0]   ratio_x;
   logic [CNT_W:0]   high_len;
   logic [CNT_W:0]   phase_inc;

   // One extra bit so ceil(N/2) and phase+1 cannot overflow at full-scale N.
   assign ratio_x   = {1'b0, ratio};
   assign high_len  = (ratio_x + ONE_X) >> 1;
   assign phase_inc = {1'b0, phase} + ONE_X;

   assign period_end = advance && (phase_inc == ratio_x);
   assign hi_next    = (phase_inc < high_len);
   assign fall_next  = (phase_inc == high_len);

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         phase <= '0;
      end else if (advance && !period_end) begin
         phase <= phase_inc[CNT_W-1:0];
      end else begin
         phase <= '0;
      end
   end

endmodule

// File: rtl/clk_gen.sv
// Programmable clock divider: produces CLK at Clock/N with edge strobes and a
// completed-period counter. Ratio changes and stops only take effect at period ends.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | CLK held low, phase counter at 0, waiting for en
// ST_RUN  | a period is in progress; back-to-back periods while en stays 1
module clk_gen
   import clk_gen_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int DEFAULT_DIV = DEF_DIV,
   parameter int PCNT_W      = DEF_PCNT_W
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic              en,
   input  logic [CNT_W-1:0]  div_ratio,
   input  logic              load,
   output logic              CLK,
   output logic              rise_tick,
   output logic              fall_tick,
   output logic [PCNT_W-1:0] period_cnt,
   output logic              running
);

   localparam logic [CNT_W-1:0]  RESET_DIV = CNT_W'(sanitize_div(DEFAULT_DIV));
   localparam logic [PCNT_W-1:0] PCNT_ONE  = {{(PCNT_W-1){1'b0}}, 1'b1};

   clk_state_t       state;
   logic [CNT_W-1:0] act_ratio;
   logic [CNT_W-1:0] pend_ratio;
   logic [CNT_W-1:0] load_ratio;
   logic [CNT_W-1:0] next_ratio;
   logic             period_end;
   logic             hi_next;
   logic             fall_next;

   assign load_ratio = CNT_W'(sanitize_div(32'(div_ratio)));
   // A load coinciding with a period start wins over the older pending value.
   assign next_ratio = load ? load_ratio : pend_ratio;

   clk_gen_phase_ctr #(
      .CNT_W (CNT_W)
   ) u_phase_ctr (
      .Clock      (Clock),
      .Reset_n    (Reset_n),
      .advance    (running),
      .ratio      (act_ratio),
      .period_end (period_end),
      .hi_next    (hi_next),
      .fall_next  (fall_next)
   );

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= ST_IDLE;
         act_ratio  <= RESET_DIV;
         pend_ratio <= RESET_DIV;
         CLK        <= 1'b0;
         rise_tick  <= 1'b0;
         fall_tick  <= 1'b0;
         period_cnt <= '0;
         running    <= 1'b0;
      end else begin
         rise_tick <= 1'b0;
         fall_tick <= 1'b0;
         if (load) begin
            pend_ratio <= load_ratio;
         end
         case (state)
            ST_IDLE: begin
               if (en) begin
                  state     <= ST_RUN;
                  running   <= 1'b1;
                  act_ratio <= next_ratio;
                  CLK       <= 1'b1;
                  rise_tick <= 1'b1;
               end
            end
            ST_RUN: begin
               if (period_end) begin
                  period_cnt <= period_cnt + PCNT_ONE;
                  if (en) begin
                     act_ratio <= next_ratio;
                     CLK       <= 1'b1;
                     rise_tick <= 1'b1;
                  end else begin
                     state   <= ST_IDLE;
                     running <= 1'b0;
                     CLK     <= 1'b0;
                  end
               end else begin
                  CLK       <= hi_next;
                  fall_tick <= fall_next;
               end
            end
            default: begin
               state   <= ST_IDLE;
               running <= 1'b0;
               CLK     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clk_gen.sv
// Bench for clk_gen: directed scenarios with literal waveforms plus random
// stimulus, all compared every cycle against a period-position reference model.
module tb_clk_gen;

   logic        Clock;
   logic        Reset_n;
   logic        en;
   logic        load;
   logic [15:0] div_ratio;
   logic        CLK;
   logic        rise_tick;
   logic        fall_tick;
   logic [31:0] period_cnt;
   logic        running;

   int checks;
   int errors;

   // Reference model: where we are inside the current period, and its length.
   bit          m_run;
   int          m_pos;
   int          m_n;
   int          m_pend;
   logic [31:0] m_pcnt;

   logic [3:0]  pat4;
   logic [9:0]  pat10;
   logic [5:0]  pat6;

   clk_gen dut (
      .Clock      (Clock),
      .Reset_n    (Reset_n),
      .en         (en),
      .div_ratio  (div_ratio),
      .load       (load),
      .CLK        (CLK),
      .rise_tick  (rise_tick),
      .fall_tick  (fall_tick),
      .period_cnt (period_cnt),
      .running    (running)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run  = 1'b0;
      m_pos  = 0;
      m_n    = 2;
      m_pend = 2;
      m_pcnt = '0;
   endtask

   task automatic model_step();
      int np;
      if (!Reset_n) begin
         model_reset();
         return;
      end
      np = load ? ((div_ratio < 16'd2) ? 2 : int'(div_ratio)) : m_pend;
      if (!m_run) begin
         if (en) begin
            m_run = 1'b1;
            m_pos = 0;
            m_n   = np;
         end
      end else if (m_pos == m_n - 1) begin
         m_pcnt = m_pcnt + 32'd1;
         m_pos  = 0;
         if (en) m_n = np;
         else    m_run = 1'b0;
      end else begin
         m_pos = m_pos + 1;
      end
      m_pend = np;
   endtask

   task automatic compare_all();
      int h;
      h = (m_n + 1) / 2;
      chk1("clk", CLK, m_run && (m_pos < h));
      chk1("rise_tick", rise_tick, m_run && (m_pos == 0));
      chk1("fall_tick", fall_tick, m_run && (m_pos == h));
      chk1("running", running, m_run);
      chk32("period_cnt", period_cnt, m_pcnt);
   endtask

   task automatic step(input logic e, input logic ld, input logic [15:0] dr);
      en        = e;
      load      = ld;
      div_ratio = dr;
      @(posedge Clock);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      step(1'b0, 1'b0, 16'd0);
      Reset_n = 1'b1;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      en        = 1'b1;
      load      = 1'b0;
      div_ratio = '0;
      Reset_n   = 1'b0;
      model_reset();

      // Reset held with en=1: everything quiet.
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 16'd0);
         chk1("rst_clk", CLK, 1'b0);
         chk1("rst_running", running, 1'b0);
         chk32("rst_pcnt", period_cnt, 32'd0);
      end

      // Release with en=1: default divide-by-2, first high cycle right away.
      Reset_n = 1'b1;
      pat4 = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 16'd0);
         chk1("div2_clk", CLK, pat4[3-i]);
         chk1("div2_rise", rise_tick, pat4[3-i]);
      end

      // N=4: 2 high / 2 low, three periods complete after 12 running cycles.
      do_reset();
      step(1'b0, 1'b1, 16'd4);
      pat4 = 4'b1100;
      for (int i = 0; i < 13; i++) begin
         step(1'b1, 1'b0, 16'd0);
         if (i < 4) chk1("div4_clk", CLK, pat4[3-i]);
      end
      chk32("div4_pcnt", period_cnt, 32'd3);

      // N=5: 3 high / 2 low.
      do_reset();
      step(1'b0, 1'b1, 16'd5);
      pat10 = 10'b1110011100;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, 16'd0);
         chk1("div5_clk", CLK, pat10[9-i]);
      end

      // Ratios 0 and 1 clamp to divide-by-2.
      for (int r = 0; r < 2; r++) begin
         do_reset();
         step(1'b0, 1'b1, 16'(r));
         pat4 = 4'b1010;
         for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 16'd0);
            chk1("div_small_clk", CLK, pat4[3-i]);
         end
      end

      // N=6 with a load of 4 mid-period: 3/3 then 2/2.
      do_reset();
      step(1'b0, 1'b1, 16'd6);
      pat10 = 10'b1110001100;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, (i == 1), 16'd4);
         chk1("ratio_change_clk", CLK, pat10[9-i]);
      end

      // N=4, en dropped in the first high cycle: period completes, then stops.
      do_reset();
      step(1'b0, 1'b1, 16'd4);
      pat6 = 6'b110000;
      for (int i = 0; i < 6; i++) begin
         step((i == 0), 1'b0, 16'd0);
         chk1("stop_clk", CLK, pat6[5-i]);
      end
      chk1("stop_running", running, 1'b0);
      chk32("stop_pcnt", period_cnt, 32'd1);
      step(1'b1, 1'b0, 16'd0);
      chk1("restart_clk", CLK, 1'b1);
      chk1("restart_rise", rise_tick, 1'b1);

      // Asynchronous reset in the middle of a high phase.
      step(1'b1, 1'b0, 16'd0);
      chk1("pre_async_clk", CLK, 1'b1);
      #2;
      Reset_n = 1'b0;
      #1;
      model_reset();
      chk1("async_clk", CLK, 1'b0);
      chk1("async_running", running, 1'b0);
      chk1("async_rise", rise_tick, 1'b0);
      chk1("async_fall", fall_tick, 1'b0);
      chk32("async_pcnt", period_cnt, 32'd0);
      step(1'b1, 1'b0, 16'd0);
      Reset_n = 1'b1;
      pat4 = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 16'd0);
         chk1("post_async_clk", CLK, pat4[3-i]);
      end

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic e;
         logic ld;
         logic [15:0] dr;
         e  = ($urandom_range(0, 9) != 0);
         ld = ($urandom_range(0, 11) == 0);
         dr = 16'($urandom_range(0, 9));
         if ($urandom_range(0, 599) == 0) begin
            do_reset();
         end else begin
            step(e, ld, dr);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
